// File: rtl/computie_bus_pkg.sv
// Shared types and constants for the Computie bus tracer.
// Latency: n/a (package only).
// Backpressure: n/a.
// Contents: strobe polarity constants, bus/capture/dump FSM state enums,
// ASCII characters used in the dump text, and a nibble-to-hex helper.
package computie_bus_pkg;

    // Computie bus strobes and reset are active-low.
    localparam logic ACTIVE   = 1'b0;
    localparam logic INACTIVE = 1'b1;

    localparam int TS_W    = 16;
    localparam int TS_NIBS = TS_W / 4;

    typedef enum logic [1:0] {
        B_IDLE,
        B_ADDR,
        B_DATA
    } bus_state_t;

    typedef enum logic [1:0] {
        C_IDLE,
        C_ARMED,
        C_POST,
        C_DONE
    } cap_state_t;

    typedef enum logic [2:0] {
        D_IDLE,
        D_RW,
        D_ADDR,
        D_SEP,
        D_DATA,
        D_TS,
        D_NL,
        D_DONE
    } dump_state_t;

    localparam logic [7:0] CH_R     = 8'h52;
    localparam logic [7:0] CH_W     = 8'h57;
    localparam logic [7:0] CH_COLON = 8'h3A;
    localparam logic [7:0] CH_AT    = 8'h40;
    localparam logic [7:0] CH_NL    = 8'h0A;

    // Uppercase ASCII hex digit for a nibble.
    function automatic logic [7:0] nib_to_hex(input logic [3:0] n);
        if (n < 4'd10) begin
            return 8'h30 + {4'h0, n};
        end
        return 8'h37 + {4'h0, n};
    endfunction

endpackage

// File: rtl/computie_bus_tracer_if.sv
// Bundle of host control, dump byte stream and Computie bus pins.
// Latency: n/a (wiring only).
// Backpressure: out_valid/out_ready stream; byte moves when both are high.
// slave  = the tracer (consumes controls and bus pins, drives stream/status).
// master = host/bus side (drives controls and bus pins, sinks the stream).
interface computie_bus_tracer_if #(
    parameter int BITWIDTH = 32
);
    logic                record_start;
    logic                record_trigger;
    logic                record_end;
    logic                dump_start;
    logic                dump_end;
    logic                out_valid;
    logic                out_ready;
    logic [7:0]          out_data;
    logic                cb_reset;
    logic                cb_addr_strobe;
    logic                cb_data_strobe;
    logic                cb_read_write;
    logic [BITWIDTH-1:0] cb_addr_data_bus;
    logic                send_receive;
    logic                data_dir;
    logic                addr_oe;
    logic                data_oe;

    modport slave (
        input  record_start, record_trigger, dump_start, out_ready,
        input  cb_reset, cb_addr_strobe, cb_data_strobe, cb_read_write, cb_addr_data_bus,
        output record_end, dump_end, out_valid, out_data,
        output send_receive, data_dir, addr_oe, data_oe
    );

    modport master (
        output record_start, record_trigger, dump_start, out_ready,
        output cb_reset, cb_addr_strobe, cb_data_strobe, cb_read_write, cb_addr_data_bus,
        input  record_end, dump_end, out_valid, out_data,
        input  send_receive, data_dir, addr_oe, data_oe
    );
endinterface

// File: rtl/computie_bus_sync.sv
// Two-flop synchronizer for a vector of asynchronous inputs.
// Latency: 2 i_clk cycles from input change to o_q.
// Backpressure: none.
// Ports: i_clk, i_rst (sync, active-high, loads RST_VAL), i_d async in, o_q synced out.
module computie_bus_sync #(
    parameter int               WIDTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_meta <= RST_VAL;
            r_sync <= RST_VAL;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/computie_bus_tracer.sv
// Trigger-based Computie bus cycle tracer with ASCII dump of a circular record buffer.
// Latency: bus edge acted on at 3rd comm_clock edge; dump_start -> first byte 1 cycle later.
// Backpressure: out_data held until out_valid&&out_ready; next byte one cycle after transfer.
// Ports: comm_clock, comm_reset (sync, active-high); bus = computie_bus_tracer_if.slave
// carrying record/dump controls, the byte stream and the Computie bus pins.
// Optional: COMPUTIE_BUS_TRACER_TIMESTAMP_EN adds a 16-bit per-record timestamp
// printed as "@XXXX" before each newline.
module computie_bus_tracer
    import computie_bus_pkg::*;
#(
    parameter int BITWIDTH     = 32,
    parameter int DEPTH        = 32,
    parameter int POST_TRIGGER = 8
) (
    input  logic                   comm_clock,
    input  logic                   comm_reset,
    computie_bus_tracer_if.slave   bus
);

    localparam int AW   = $clog2(DEPTH);
    localparam int CW   = AW + 1;
    localparam int NIBS = BITWIDTH / 4;
    localparam int NW   = $clog2(NIBS + 5);
    localparam int SW   = BITWIDTH + 4;
    localparam logic [CW-1:0] POST_CNT = CW'(POST_TRIGGER);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    // ---------------- synchronizer ----------------
    logic [SW-1:0]       w_sync;
    logic                w_s_rst_n;
    logic                w_s_as;
    logic                w_s_ds;
    logic                w_s_rw;
    logic [BITWIDTH-1:0] w_s_bus;

    computie_bus_sync #(
        .WIDTH   (SW),
        .RST_VAL ({4'b1110, {BITWIDTH{1'b0}}})
    ) u_sync (
        .i_clk (comm_clock),
        .i_rst (comm_reset),
        .i_d   ({bus.cb_reset, bus.cb_addr_strobe, bus.cb_data_strobe,
                 bus.cb_read_write, bus.cb_addr_data_bus}),
        .o_q   (w_sync)
    );

    assign w_s_rst_n = w_sync[SW-1];
    assign w_s_as    = w_sync[SW-2];
    assign w_s_ds    = w_sync[SW-3];
    assign w_s_rw    = w_sync[SW-4];
    assign w_s_bus   = w_sync[BITWIDTH-1:0];

    // ---------------- state ----------------
    bus_state_t          r_bstate;
    cap_state_t          r_cstate;
    dump_state_t         r_dstate;
    logic                r_addr_oe;
    logic                r_data_oe;
    logic [BITWIDTH-1:0] r_cur_addr;
    logic [BITWIDTH-1:0] r_cur_data;
    logic                r_cur_rw;
    logic [AW-1:0]       r_wptr;
    logic [CW-1:0]       r_count;
    logic [CW-1:0]       r_post;
    logic                r_record_end;
    logic [AW-1:0]       r_rptr;
    logic [CW-1:0]       r_left;
    logic [NW-1:0]       r_nib;
    logic                r_out_valid;
    logic [7:0]          r_out_data;
    logic                r_dump_end;

    logic [BITWIDTH-1:0] r_mem_addr [DEPTH];
    logic [BITWIDTH-1:0] r_mem_data [DEPTH];
    logic                r_mem_rw   [DEPTH];

`ifdef COMPUTIE_BUS_TRACER_TIMESTAMP_EN
    logic [TS_W-1:0]     r_ts;
    logic [TS_W-1:0]     r_cur_ts;
    logic [TS_W-1:0]     r_mem_ts   [DEPTH];
`endif

    logic          w_dump_busy;
    logic          w_start;
    logic          w_commit;
    logic          w_we;
    logic          w_dump_go;
    logic [AW-1:0] w_start_idx;
    logic [7:0]    w_byte;

    assign w_dump_busy = (r_dstate != D_IDLE) && (r_dstate != D_DONE);
    // A restart request during an active dump is dropped so the text stays coherent.
    assign w_start     = bus.record_start && !w_dump_busy;
    assign w_commit    = (r_bstate == B_DATA) && (w_s_rst_n == INACTIVE)
                         && (w_s_ds == INACTIVE) && !w_start;
    assign w_we        = w_commit && ((r_cstate == C_ARMED) || (r_cstate == C_POST));
    assign w_dump_go   = bus.dump_start && !w_dump_busy
                         && ((r_cstate == C_IDLE) || (r_cstate == C_DONE));
    // Oldest record; when full, count's low bits are zero so this lands on wptr.
    assign w_start_idx = r_wptr - r_count[AW-1:0];

`ifdef COMPUTIE_BUS_TRACER_TIMESTAMP_EN
    always_ff @(posedge comm_clock) begin
        if (comm_reset || w_start) begin
            r_ts <= '0;
        end else begin
            r_ts <= r_ts + 1'b1;
        end
    end
`endif

    // ---------------- bus cycle FSM ----------------
    always_ff @(posedge comm_clock) begin
        if (comm_reset) begin
            r_bstate   <= B_IDLE;
            r_addr_oe  <= 1'b1;
            r_data_oe  <= 1'b1;
            r_cur_addr <= '0;
            r_cur_data <= '0;
            r_cur_rw   <= 1'b0;
`ifdef COMPUTIE_BUS_TRACER_TIMESTAMP_EN
            r_cur_ts   <= '0;
`endif
        end else if ((w_s_rst_n == ACTIVE) || w_start) begin
            r_bstate  <= B_IDLE;
            r_addr_oe <= 1'b1;
            r_data_oe <= 1'b1;
        end else begin
            case (r_bstate)
                B_IDLE: begin
                    if (w_s_as == ACTIVE) begin
                        r_cur_addr <= w_s_bus;
`ifdef COMPUTIE_BUS_TRACER_TIMESTAMP_EN
                        r_cur_ts   <= r_ts;
`endif
                        r_addr_oe  <= 1'b0;
                        r_bstate   <= B_ADDR;
                    end
                end
                B_ADDR: begin
                    if (w_s_ds == ACTIVE) begin
                        r_cur_data <= w_s_bus;
                        r_cur_rw   <= w_s_rw;
                        r_data_oe  <= 1'b0;
                        r_addr_oe  <= 1'b1;
                        r_bstate   <= B_DATA;
                    end
                end
                B_DATA: begin
                    if (w_s_ds == INACTIVE) begin
                        r_data_oe <= 1'b1;
                        r_bstate  <= B_IDLE;
                    end
                end
                default: begin
                    r_bstate <= B_IDLE;
                end
            endcase
        end
    end

    // ---------------- record buffer ----------------
    always_ff @(posedge comm_clock) begin
        if (w_we) begin
            r_mem_addr[r_wptr] <= r_cur_addr;
            r_mem_data[r_wptr] <= r_cur_data;
            r_mem_rw[r_wptr]   <= r_cur_rw;
`ifdef COMPUTIE_BUS_TRACER_TIMESTAMP_EN
            r_mem_ts[r_wptr]   <= r_cur_ts;
`endif
        end
    end

    // ---------------- capture FSM ----------------
    always_ff @(posedge comm_clock) begin
        if (comm_reset) begin
            r_cstate     <= C_IDLE;
            r_wptr       <= '0;
            r_count      <= '0;
            r_post       <= '0;
            r_record_end <= 1'b0;
        end else if (w_start) begin
            r_cstate     <= C_ARMED;
            r_wptr       <= '0;
            r_count      <= '0;
            r_post       <= '0;
            r_record_end <= 1'b0;
        end else begin
            case (r_cstate)
                C_ARMED: begin
                    // A commit on the trigger cycle is still a pre-trigger record.
                    if (w_commit) begin
                        r_wptr <= r_wptr + 1'b1;
                        if (r_count != FULL_CNT) begin
                            r_count <= r_count + 1'b1;
                        end
                    end
                    if (bus.record_trigger) begin
                        r_post <= '0;
                        if (POST_CNT == '0) begin
                            r_cstate     <= C_DONE;
                            r_record_end <= 1'b1;
                        end else begin
                            r_cstate <= C_POST;
                        end
                    end
                end
                C_POST: begin
                    if (w_commit) begin
                        r_wptr <= r_wptr + 1'b1;
                        if (r_count != FULL_CNT) begin
                            r_count <= r_count + 1'b1;
                        end
                        r_post <= r_post + 1'b1;
                        if ((r_post + 1'b1) == POST_CNT) begin
                            r_cstate     <= C_DONE;
                            r_record_end <= 1'b1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // ---------------- dump text generator ----------------
    always_comb begin
        w_byte = 8'h00;
        case (r_dstate)
            D_RW:    w_byte = r_mem_rw[r_rptr] ? CH_R : CH_W;
            D_ADDR:  w_byte = nib_to_hex(4'(r_mem_addr[r_rptr] >> {r_nib, 2'b00}));
            D_SEP:   w_byte = CH_COLON;
            D_DATA:  w_byte = nib_to_hex(4'(r_mem_data[r_rptr] >> {r_nib, 2'b00}));
`ifdef COMPUTIE_BUS_TRACER_TIMESTAMP_EN
            // Nibble index TS_NIBS is the '@' marker, then TS_NIBS digits.
            D_TS:    w_byte = (r_nib == NW'(TS_NIBS)) ? CH_AT
                              : nib_to_hex(4'(r_mem_ts[r_rptr] >> {r_nib, 2'b00}));
`endif
            D_NL:    w_byte = CH_NL;
            default: w_byte = 8'h00;
        endcase
    end

    // ---------------- dump FSM ----------------
    // Each byte takes a load cycle (valid rises) and a transfer cycle (valid falls),
    // which caps the stream at one byte per two cycles.
    always_ff @(posedge comm_clock) begin
        if (comm_reset) begin
            r_dstate    <= D_IDLE;
            r_rptr      <= '0;
            r_left      <= '0;
            r_nib       <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= 8'h00;
            r_dump_end  <= 1'b0;
        end else if (w_start) begin
            r_dstate    <= D_IDLE;
            r_out_valid <= 1'b0;
            r_dump_end  <= 1'b0;
        end else if (w_dump_go) begin
            r_rptr <= w_start_idx;
            r_left <= r_count;
            if (r_count == '0) begin
                r_dstate   <= D_DONE;
                r_dump_end <= 1'b1;
            end else begin
                r_dstate    <= D_RW;
                r_dump_end  <= 1'b0;
                r_out_data  <= r_mem_rw[w_start_idx] ? CH_R : CH_W;
                r_out_valid <= 1'b1;
            end
        end else if (w_dump_busy) begin
            if (!r_out_valid) begin
                r_out_data  <= w_byte;
                r_out_valid <= 1'b1;
            end else if (bus.out_ready) begin
                r_out_valid <= 1'b0;
                case (r_dstate)
                    D_RW: begin
                        r_dstate <= D_ADDR;
                        r_nib    <= NW'(NIBS - 1);
                    end
                    D_ADDR: begin
                        if (r_nib == '0) begin
                            r_dstate <= D_SEP;
                        end else begin
                            r_nib <= r_nib - 1'b1;
                        end
                    end
                    D_SEP: begin
                        r_dstate <= D_DATA;
                        r_nib    <= NW'(NIBS - 1);
                    end
                    D_DATA: begin
                        if (r_nib == '0) begin
`ifdef COMPUTIE_BUS_TRACER_TIMESTAMP_EN
                            r_dstate <= D_TS;
                            r_nib    <= NW'(TS_NIBS);
`else
                            r_dstate <= D_NL;
`endif
                        end else begin
                            r_nib <= r_nib - 1'b1;
                        end
                    end
                    D_TS: begin
                        if (r_nib == '0) begin
                            r_dstate <= D_NL;
                        end else begin
                            r_nib <= r_nib - 1'b1;
                        end
                    end
                    D_NL: begin
                        if (r_left == CW'(1)) begin
                            r_dstate   <= D_DONE;
                            r_dump_end <= 1'b1;
                        end else begin
                            r_left   <= r_left - 1'b1;
                            r_rptr   <= r_rptr + 1'b1;
                            r_dstate <= D_RW;
                        end
                    end
                    default: begin
                        r_dstate <= D_IDLE;
                    end
                endcase
            end
        end
    end

    // ---------------- outputs ----------------
    assign bus.record_end   = r_record_end;
    assign bus.dump_end     = r_dump_end;
    assign bus.out_valid    = r_out_valid;
    assign bus.out_data     = r_out_data;
    assign bus.addr_oe      = r_addr_oe;
    assign bus.data_oe      = r_data_oe;
    // Receive-only: transceivers always point into the tracer.
    assign bus.send_receive = 1'b0;
    assign bus.data_dir     = 1'b0;

endmodule

// File: tb/tb_computie_bus_tracer.sv
// Directed bench for computie_bus_tracer: two instances share one bus.
// u_a: DEPTH 32, POST_TRIGGER 0.  u_b: DEPTH 4, POST_TRIGGER 2.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_computie_bus_tracer;

    logic        clk;
    logic        rst;
    logic [1:0]  rs;
    logic [1:0]  trig;
    logic [1:0]  dst;
    logic [1:0]  rdy;
    logic        cb_rst_n;
    logic        as_n;
    logic        ds_n;
    logic        rw;
    logic [31:0] bus_v;

    logic [1:0]  w_valid;
    logic [1:0]  w_dend;
    logic [1:0]  w_rend;
    logic [1:0]  w_aoe;
    logic [1:0]  w_doe;
    logic [7:0]  w_data [2];

    int          n_tests = 0;
    int          n_fail  = 0;
    int          stab_err;
    logic [15:0] tsq [$];

    computie_bus_tracer_if #(.BITWIDTH(32)) if_a ();
    computie_bus_tracer_if #(.BITWIDTH(32)) if_b ();

    assign if_a.record_start     = rs[0];
    assign if_a.record_trigger   = trig[0];
    assign if_a.dump_start       = dst[0];
    assign if_a.out_ready        = rdy[0];
    assign if_a.cb_reset         = cb_rst_n;
    assign if_a.cb_addr_strobe   = as_n;
    assign if_a.cb_data_strobe   = ds_n;
    assign if_a.cb_read_write    = rw;
    assign if_a.cb_addr_data_bus = bus_v;

    assign if_b.record_start     = rs[1];
    assign if_b.record_trigger   = trig[1];
    assign if_b.dump_start       = dst[1];
    assign if_b.out_ready        = rdy[1];
    assign if_b.cb_reset         = cb_rst_n;
    assign if_b.cb_addr_strobe   = as_n;
    assign if_b.cb_data_strobe   = ds_n;
    assign if_b.cb_read_write    = rw;
    assign if_b.cb_addr_data_bus = bus_v;

    assign w_valid[0] = if_a.out_valid;
    assign w_valid[1] = if_b.out_valid;
    assign w_dend[0]  = if_a.dump_end;
    assign w_dend[1]  = if_b.dump_end;
    assign w_rend[0]  = if_a.record_end;
    assign w_rend[1]  = if_b.record_end;
    assign w_aoe[0]   = if_a.addr_oe;
    assign w_aoe[1]   = if_b.addr_oe;
    assign w_doe[0]   = if_a.data_oe;
    assign w_doe[1]   = if_b.data_oe;
    assign w_data[0]  = if_a.out_data;
    assign w_data[1]  = if_b.out_data;

    computie_bus_tracer #(.BITWIDTH(32), .DEPTH(32), .POST_TRIGGER(0)) u_a (
        .comm_clock (clk),
        .comm_reset (rst),
        .bus        (if_a)
    );

    computie_bus_tracer #(.BITWIDTH(32), .DEPTH(4), .POST_TRIGGER(2)) u_b (
        .comm_clock (clk),
        .comm_reset (rst),
        .bus        (if_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_str(input string tag, input string obs, input string exp);
        n_tests++;
        assert (obs == exp) else begin
            n_fail++;
            $error("FAIL %s: observed \"%s\" expected \"%s\"", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] hex_val(input logic [7:0] c);
        if (c >= 8'h41) return 4'(c - 8'h37);
        return 4'(c - 8'h30);
    endfunction

    // Number of '@' markers expected in a dump of n lines.
    function automatic int exp_at(input int n);
`ifdef COMPUTIE_BUS_TRACER_TIMESTAMP_EN
        return n;
`else
        if (n < 0) return n;
        return 0;
`endif
    endfunction

    task automatic pulse_rs(input int k);
        rs[k] = 1'b1;
        @(negedge clk);
        rs[k] = 1'b0;
    endtask

    task automatic pulse_trig(input int k);
        trig[k] = 1'b1;
        @(negedge clk);
        trig[k] = 1'b0;
    endtask

    // One complete bus cycle, 12 clocks long; caller is at a falling edge.
    task automatic bus_cycle(input logic r, input logic [31:0] a, input logic [31:0] d,
                             input bit chk);
        bus_v = a;
        rw    = r;
        as_n  = 1'b0;
        repeat (4) @(negedge clk);
        if (chk) check("addr_oe_in_addr_phase", {63'd0, w_aoe[0]}, 64'd0);
        bus_v = d;
        ds_n  = 1'b0;
        repeat (4) @(negedge clk);
        if (chk) begin
            check("addr_oe_in_data_phase", {63'd0, w_aoe[0]}, 64'd1);
            check("data_oe_in_data_phase", {63'd0, w_doe[0]}, 64'd0);
        end
        as_n = 1'b1;
        ds_n = 1'b1;
        repeat (4) @(negedge clk);
        if (chk) check("data_oe_after_cycle", {63'd0, w_doe[0]}, 64'd1);
    endtask

    // Start a dump on instance k and collect the text; "@XXXX" fields go to tsq.
    task automatic dump_read(input int k, input bit stall, output string s, output int n_at);
        int          cyc;
        bit          done;
        bit          prev_pend;
        logic [7:0]  prev_d;
        logic [7:0]  b;
        int          ts_left;
        logic [15:0] tsv;
        s         = "";
        n_at      = 0;
        done      = 1'b0;
        prev_pend = 1'b0;
        prev_d    = 8'h00;
        ts_left   = 0;
        tsv       = 16'h0;
        stab_err  = 0;
        tsq.delete();
        dst[k] = 1'b1;
        @(negedge clk);
        dst[k] = 1'b0;
        check("first_byte_latency", {63'd0, w_valid[k]}, 64'd1);
        cyc = 0;
        while (!done && cyc < 3000) begin
            rdy[k] = stall ? (((cyc / 3) % 2) == 1) : 1'b1;
            if (prev_pend) begin
                if (!w_valid[k] || (w_data[k] !== prev_d)) stab_err++;
            end
            if (w_valid[k] && rdy[k]) begin
                b = w_data[k];
                if (b == 8'h40) begin
                    n_at++;
                    ts_left = 4;
                end else if (ts_left > 0) begin
                    tsv = {tsv[11:0], hex_val(b)};
                    ts_left--;
                    if (ts_left == 0) tsq.push_back(tsv);
                end else begin
                    s = $sformatf("%s%c", s, b);
                end
            end
            prev_pend = w_valid[k] && !rdy[k];
            prev_d    = w_data[k];
            if (w_dend[k]) done = 1'b1;
            @(negedge clk);
            cyc++;
        end
        rdy[k] = 1'b0;
        check("dump_completes_in_budget", {63'd0, done}, 64'd1);
    endtask

    initial begin
        string s;
        string s2;
        int    n_at;
        string exp_a;
        string exp_b;

        rst      = 1'b1;
        rs       = 2'b00;
        trig     = 2'b00;
        dst      = 2'b00;
        rdy      = 2'b00;
        cb_rst_n = 1'b1;
        as_n     = 1'b1;
        ds_n     = 1'b1;
        rw       = 1'b0;
        bus_v    = 32'h0;
        repeat (4) @(negedge clk);

        // Reset state.
        check("rst_record_end", {63'd0, w_rend[0]}, 64'd0);
        check("rst_dump_end",   {63'd0, w_dend[0]}, 64'd0);
        check("rst_out_valid",  {63'd0, w_valid[0]}, 64'd0);
        check("rst_out_data",   {56'd0, w_data[0]}, 64'd0);
        check("rst_addr_oe",    {63'd0, w_aoe[0]}, 64'd1);
        check("rst_data_oe",    {63'd0, w_doe[0]}, 64'd1);
        check("send_receive",   {63'd0, if_a.send_receive}, 64'd0);
        check("data_dir",       {63'd0, if_a.data_dir}, 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // Empty dump on B: no bytes, dump_end on the next cycle.
        dst[1] = 1'b1;
        @(negedge clk);
        dst[1] = 1'b0;
        check("empty_dump_end",   {63'd0, w_dend[1]}, 64'd1);
        check("empty_dump_valid", {63'd0, w_valid[1]}, 64'd0);
        repeat (3) @(negedge clk);
        check("empty_dump_valid_later", {63'd0, w_valid[1]}, 64'd0);

        // A: three cycles then trigger with no post-trigger window.
        pulse_rs(0);
        check("armed_record_end", {63'd0, w_rend[0]}, 64'd0);
        bus_cycle(1'b0, 32'h0000_1000, 32'hDEAD_BEEF, 1'b1);
        bus_cycle(1'b1, 32'h0000_2000, 32'h1234_5678, 1'b0);
        bus_cycle(1'b0, 32'h0000_3000, 32'hCAFE_F00D, 1'b0);
        check("pre_trigger_record_end", {63'd0, w_rend[0]}, 64'd0);
        // Dump request while armed is ignored.
        dst[0] = 1'b1;
        @(negedge clk);
        dst[0] = 1'b0;
        @(negedge clk);
        check("dump_while_armed_valid", {63'd0, w_valid[0]}, 64'd0);
        check("dump_while_armed_end",   {63'd0, w_dend[0]}, 64'd0);
        pulse_trig(0);
        check("trigger_record_end", {63'd0, w_rend[0]}, 64'd1);
        check("idle_b_record_end",  {63'd0, w_rend[1]}, 64'd0);

        exp_a = "W00001000:DEADBEEF\nR00002000:12345678\nW00003000:CAFEF00D\n";
        dump_read(0, 1'b0, s, n_at);
        check_str("dump_full_rate", s, exp_a);
        check("dump_full_at_count", 64'(n_at), 64'(exp_at(3)));
        check("dump_end_after_dump", {63'd0, w_dend[0]}, 64'd1);
        dump_read(0, 1'b1, s2, n_at);
        check_str("dump_stalled", s2, exp_a);
        check("stall_data_stable", 64'(stab_err), 64'd0);

        // A: restart mid-capture drops records; bus reset aborts a cycle.
        pulse_rs(0);
        check("restart_record_end", {63'd0, w_rend[0]}, 64'd0);
        check("restart_dump_end",   {63'd0, w_dend[0]}, 64'd0);
        bus_cycle(1'b1, 32'h0000_5000, 32'h5555_0000, 1'b0);
        bus_cycle(1'b0, 32'h0000_6000, 32'h6666_0000, 1'b0);
        pulse_rs(0);
        bus_v = 32'h0000_8000;
        rw    = 1'b1;
        as_n  = 1'b0;
        repeat (4) @(negedge clk);
        check("abort_addr_oe_active", {63'd0, w_aoe[0]}, 64'd0);
        cb_rst_n = 1'b0;
        repeat (4) @(negedge clk);
        check("abort_addr_oe_released", {63'd0, w_aoe[0]}, 64'd1);
        as_n     = 1'b1;
        cb_rst_n = 1'b1;
        repeat (4) @(negedge clk);
        bus_cycle(1'b1, 32'h0000_7000, 32'h0BAD_F00D, 1'b0);
        pulse_trig(0);
        check("second_trigger_record_end", {63'd0, w_rend[0]}, 64'd1);
        dump_read(0, 1'b0, s, n_at);
        check_str("dump_after_restart_abort", s, "R00007000:0BADF00D\n");

        // B: DEPTH 4, ten pre-trigger cycles, two post-trigger cycles.
        pulse_rs(1);
        for (int i = 1; i <= 10; i++) begin
            bus_cycle(i[0], 32'(i) << 12, 32'(i) * 32'h1111_1111, 1'b0);
        end
        pulse_trig(1);
        check("post_window_open", {63'd0, w_rend[1]}, 64'd0);
        bus_cycle(1'b1, 32'h0000_B000, 32'hBBBB_BBBB, 1'b0);
        check("post_one_of_two", {63'd0, w_rend[1]}, 64'd0);
        bus_cycle(1'b0, 32'h0000_C000, 32'hCCCC_CCCC, 1'b0);
        check("post_two_of_two", {63'd0, w_rend[1]}, 64'd1);
        exp_b = "R00009000:99999999\nW0000A000:AAAAAAAA\nR0000B000:BBBBBBBB\nW0000C000:CCCCCCCC\n";
        dump_read(1, 1'b0, s, n_at);
        check_str("dump_wrapped", s, exp_b);
        check("dump_wrapped_at_count", 64'(n_at), 64'(exp_at(4)));

`ifdef COMPUTIE_BUS_TRACER_TIMESTAMP_EN
        // Two address latches exactly 100 clocks apart.
        pulse_rs(0);
        bus_cycle(1'b0, 32'h0000_0100, 32'h0000_0001, 1'b0);
        repeat (88) @(negedge clk);
        bus_cycle(1'b1, 32'h0000_0200, 32'h0000_0002, 1'b0);
        pulse_trig(0);
        dump_read(0, 1'b0, s, n_at);
        check_str("ts_dump_text", s, "W00000100:00000001\nR00000200:00000002\n");
        check("ts_at_count", 64'(n_at), 64'd2);
        check("ts_field_count", 64'(tsq.size()), 64'd2);
        if (tsq.size() == 2) begin
            check("ts_delta", {48'd0, tsq[1] - tsq[0]}, 64'd100);
        end
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
